jtag_tap_resp: RTL and testbench
================================

JTAG_TAP_RESP -- requirements
Module: jtag_tap_resp

Interface
REQ-001 Parameter IdcodeValue, default 32'h1E200A6D, IDCODE register capture value (bit 0 SHALL be 1).
REQ-002 Parameter IrWidth, default 5, instruction register width.
REQ-003 Parameter UserDrWidth, default 32, user data register width.
REQ-004 clk_i  input  1  sole clock; all flops on posedge clk_i.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 jtag_tck_i  input  1  JTAG TCK, asynchronous to clk_i.
REQ-007 jtag_tms_i  input  1  JTAG TMS, asynchronous.
REQ-008 jtag_tdi_i  input  1  JTAG TDI, asynchronous.
REQ-009 jtag_trst_ni  input  1  JTAG test reset, active-low, asynchronous.
REQ-010 jtag_tdo_o  output  1  JTAG TDO.
REQ-011 jtag_tdo_oe_o  output  1  TDO valid: high only in Shift-DR/Shift-IR.
REQ-012 user_dr_i  input  UserDrWidth  value loaded in Capture-DR when USER is selected.
REQ-013 user_dr_o  output  UserDrWidth  last value committed in Update-DR under USER.
REQ-014 user_update_o  output  1  one-clk_i pulse on USER Update-DR.
REQ-015 tap_state_o  output  4  current TAP state (package encoding).
REQ-016 ir_o  output  IrWidth  current committed instruction.

Function
REQ-017 tck, tms, tdi and trst_n SHALL each pass a 2-flop synchronizer; tck gets a third flop for edge detection.
REQ-018 TCK rise: synchronized tck==1 and previous==0; TCK fall: the inverse; detection lags the raw edge by 3 clk_i cycles.
REQ-019 Legal TCK high and low phases SHALL each be >=4 clk_i cycles; shorter phases are unsupported.
REQ-020 On each TCK rise the 16-state IEEE 1149.1 TAP FSM SHALL advance on synchronized tms, one transition per rise.
REQ-021 Register actions SHALL use the state held before the rise: Capture-* loads, Shift-* shifts right with tdi into MSB, Update-* commits.
REQ-022 Capture-IR SHALL load IrWidth'b0...01; Update-IR SHALL copy the IR shift register to ir_o.
REQ-023 Instructions: 5'h01 IDCODE (32-bit), 5'h10 USER (UserDrWidth), 5'h1F and all others BYPASS (1 bit, captures 0).
REQ-024 Capture-DR under IDCODE loads IdcodeValue; under USER loads user_dr_i sampled that cycle.
REQ-025 Update-DR under USER SHALL copy the shift register to user_dr_o and pulse user_update_o for exactly 1 cycle; other instructions produce no pulse.
REQ-026 On each TCK fall, jtag_tdo_o SHALL take the LSB of the IR or selected DR shift register if the state is Shift-IR/Shift-DR, else 0; jtag_tdo_oe_o updates at the same time.
REQ-027 Synchronized trst_n==0 SHALL force Test-Logic-Reset and ir_o=IDCODE in the next cycle, overriding any simultaneous TCK edge.
REQ-028 Five TCK rises with tms=1 from any state SHALL reach Test-Logic-Reset; entering that state loads ir_o=IDCODE.
REQ-029 user_dr_o SHALL be unaffected by TAP reset, holding its last committed value until rst_i.

Reset
REQ-030 rst_i SHALL set: state Test-Logic-Reset, ir_o=5'h01, shift registers 0, user_dr_o 0, user_update_o 0, jtag_tdo_o 0, jtag_tdo_oe_o 0, synchronizer flops 0 (trst_n chain to 1).
REQ-031 rst_i asserted mid-shift SHALL abort the scan with no Update and no user_update_o pulse.

Structure
REQ-032 Package jtag_tap_pkg SHALL hold tap_state_e (4-bit, 16 states) and instruction constants IR_IDCODE, IR_USER, IR_BYPASS.
REQ-033 The state transition logic SHALL be one sub-module, jtag_tap_fsm (state, tms, advance strobe -> next state); all else stays in jtag_tap_resp.

Verification
REQ-034 After rst_i, tms=1 x5, then 0,1,0,0 to Shift-DR, 32 shifts -> TDO stream LSB-first = 32'h1E200A6D.
REQ-035 Shift IR 5'h10, Update-IR; Shift-DR 32'hCAFEF00D in while user_dr_i=32'h12345678 -> TDO returns 32'h12345678, user_dr_o=32'hCAFEF00D, exactly one user_update_o pulse.
REQ-036 IR=5'h07 (undefined), shift 0xA5 through DR -> TDO reproduces 0xA5 delayed by 1 bit (BYPASS, first bit 0).
REQ-037 Shift-IR -> first 5 TDO bits = 1,0,0,0,0 (capture 5'b00001).
REQ-038 Pull jtag_trst_ni low 4 clk_i cycles while in Shift-DR under USER -> Test-Logic-Reset, ir_o=5'h01, no user_update_o, user_dr_o unchanged.
REQ-039 Assert rst_i mid Shift-DR -> all outputs at REQ-030 values next cycle, no user_update_o.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// rtl/jtag_tap_pkg.sv - TAP state encoding and instruction constants
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_USER   = 5'h10;
  localparam logic [4:0] IR_BYPASS = 5'h1F;

  localparam int IdcodeWidth = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - IEEE 1149.1 TAP next-state logic
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  tap_state_e state_i,
  input  logic       tms_i,
  input  logic       advance_i,
  output tap_state_e state_next_o
);

  always_comb begin
    state_next_o = state_i;
    if (advance_i) begin
      case (state_i)
        TEST_LOGIC_RESET: state_next_o = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_next_o = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
        SELECT_DR:        state_next_o = tms_i ? SELECT_IR  : CAPTURE_DR;
        CAPTURE_DR:       state_next_o = tms_i ? EXIT1_DR   : SHIFT_DR;
        SHIFT_DR:         state_next_o = tms_i ? EXIT1_DR   : SHIFT_DR;
        EXIT1_DR:         state_next_o = tms_i ? UPDATE_DR  : PAUSE_DR;
        PAUSE_DR:         state_next_o = tms_i ? EXIT2_DR   : PAUSE_DR;
        EXIT2_DR:         state_next_o = tms_i ? UPDATE_DR  : SHIFT_DR;
        UPDATE_DR:        state_next_o = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
        SELECT_IR:        state_next_o = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_next_o = tms_i ? EXIT1_IR   : SHIFT_IR;
        SHIFT_IR:         state_next_o = tms_i ? EXIT1_IR   : SHIFT_IR;
        EXIT1_IR:         state_next_o = tms_i ? UPDATE_IR  : PAUSE_IR;
        PAUSE_IR:         state_next_o = tms_i ? EXIT2_IR   : PAUSE_IR;
        EXIT2_IR:         state_next_o = tms_i ? UPDATE_IR  : SHIFT_IR;
        UPDATE_IR:        state_next_o = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
        default:          state_next_o = TEST_LOGIC_RESET;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap_resp.sv
// rtl/jtag_tap_resp.sv - JTAG TAP responder oversampled by the system clock
module jtag_tap_resp
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IdcodeValue = 32'h1E200A6D,
  parameter int          IrWidth     = 5,
  parameter int          UserDrWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   jtag_tck_i,
  input  logic                   jtag_tms_i,
  input  logic                   jtag_tdi_i,
  input  logic                   jtag_trst_ni,
  output logic                   jtag_tdo_o,
  output logic                   jtag_tdo_oe_o,
  input  logic [UserDrWidth-1:0] user_dr_i,
  output logic [UserDrWidth-1:0] user_dr_o,
  output logic                   user_update_o,
  output logic [3:0]             tap_state_o,
  output logic [IrWidth-1:0]     ir_o
);

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;
  logic [1:0] trst_nq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_q   <= '0;
      tms_q   <= '0;
      tdi_q   <= '0;
      trst_nq <= 2'b11;
    end else begin
      tck_q   <= {tck_q[1:0], jtag_tck_i};
      tms_q   <= {tms_q[0], jtag_tms_i};
      tdi_q   <= {tdi_q[0], jtag_tdi_i};
      trst_nq <= {trst_nq[0], jtag_trst_ni};
    end
  end

  logic tck_rise, tck_fall, tms_s, tdi_s, trst_s;
  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];
  assign trst_s   = ~trst_nq[1];

  tap_state_e state_q, state_d;

  jtag_tap_fsm u_fsm (
    .state_i      (state_q),
    .tms_i        (tms_s),
    .advance_i    (tck_rise),
    .state_next_o (state_d)
  );

  // Test reset wins over any TCK edge detected in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || trst_s) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  logic [IrWidth-1:0]     ir_q, ir_sr;
  logic [IdcodeWidth-1:0] idcode_sr;
  logic [UserDrWidth-1:0] user_sr, user_dr_q;
  logic                   bypass_sr, user_update_q, tdo_q, tdo_oe_q;
  logic                   sel_idcode, sel_user, shifting, tdo_d;

  assign sel_idcode = (ir_q == IrWidth'(IR_IDCODE));
  assign sel_user   = (ir_q == IrWidth'(IR_USER));

  // Register actions key off the state held before the rise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_q          <= IrWidth'(IR_IDCODE);
      ir_sr         <= '0;
      idcode_sr     <= '0;
      user_sr       <= '0;
      bypass_sr     <= 1'b0;
      user_dr_q     <= '0;
      user_update_q <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
    end else begin
      user_update_q <= 1'b0;
      if (trst_s) begin
        ir_q <= IrWidth'(IR_IDCODE);
      end else begin
        if (tck_rise) begin
          case (state_q)
            CAPTURE_IR: ir_sr <= IrWidth'(1);
            SHIFT_IR:   ir_sr <= {tdi_s, ir_sr[IrWidth-1:1]};
            UPDATE_IR:  ir_q  <= ir_sr;
            CAPTURE_DR: begin
              if (sel_idcode)    idcode_sr <= IdcodeValue;
              else if (sel_user) user_sr   <= user_dr_i;
              else               bypass_sr <= 1'b0;
            end
            SHIFT_DR: begin
              if (sel_idcode)    idcode_sr <= {tdi_s, idcode_sr[IdcodeWidth-1:1]};
              else if (sel_user) user_sr   <= {tdi_s, user_sr[UserDrWidth-1:1]};
              else               bypass_sr <= tdi_s;
            end
            UPDATE_DR: begin
              if (sel_user) begin
                user_dr_q     <= user_sr;
                user_update_q <= 1'b1;
              end
            end
            default: ;
          endcase
          if (state_d == TEST_LOGIC_RESET) ir_q <= IrWidth'(IR_IDCODE);
        end
        if (tck_fall) begin
          tdo_q    <= tdo_d;
          tdo_oe_q <= shifting;
        end
      end
    end
  end

  always_comb begin
    shifting = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
    tdo_d    = 1'b0;
    if (state_q == SHIFT_IR) begin
      tdo_d = ir_sr[0];
    end else if (state_q == SHIFT_DR) begin
      if (sel_idcode)    tdo_d = idcode_sr[0];
      else if (sel_user) tdo_d = user_sr[0];
      else               tdo_d = bypass_sr;
    end
  end

  assign jtag_tdo_o    = tdo_q;
  assign jtag_tdo_oe_o = tdo_oe_q;
  assign user_dr_o     = user_dr_q;
  assign user_update_o = user_update_q;
  assign tap_state_o   = state_q;
  assign ir_o          = ir_q;

endmodule

// File: tb/tb_jtag_tap_resp.sv
// tb/tb_jtag_tap_resp.sv - randomized bench for jtag_tap_resp against a TAP model
module tb_jtag_tap_resp;
  import jtag_tap_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, tck_drv, tms_drv, tdi_drv, trst_n;
  logic [31:0] user_in;
  logic        jtag_tdo_o, jtag_tdo_oe_o, user_update_o;
  logic [31:0] user_dr_o;
  logic [3:0]  tap_state_o;
  logic [4:0]  ir_o;

  jtag_tap_resp dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .jtag_tck_i    (tck_drv),
    .jtag_tms_i    (tms_drv),
    .jtag_tdi_i    (tdi_drv),
    .jtag_trst_ni  (trst_n),
    .jtag_tdo_o    (jtag_tdo_o),
    .jtag_tdo_oe_o (jtag_tdo_oe_o),
    .user_dr_i     (user_in),
    .user_dr_o     (user_dr_o),
    .user_update_o (user_update_o),
    .tap_state_o   (tap_state_o),
    .ir_o          (ir_o)
  );

  // Behavioural model: successor tables plus a variable-length DR image.
  tap_state_e  nxt0 [16];
  tap_state_e  nxt1 [16];
  tap_state_e  m_state;
  logic [4:0]  m_ir, m_irsr;
  logic [63:0] m_dr;
  int          m_len;
  logic [31:0] m_user;
  logic        m_tdo, m_oe;
  int          exp_pulses = 0;
  int          dut_pulses = 0;
  bit          check_en = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  string       lit_name;
  logic [63:0] lit_got, lit_exp;
  int          lit_seq = 0;
  int          lit_done = 0;

  task automatic edge_pair(input tap_state_e s, input tap_state_e n0, input tap_state_e n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic build_table();
    edge_pair(TEST_LOGIC_RESET, RUN_TEST_IDLE, TEST_LOGIC_RESET);
    edge_pair(RUN_TEST_IDLE,    RUN_TEST_IDLE, SELECT_DR);
    edge_pair(SELECT_DR,        CAPTURE_DR,    SELECT_IR);
    edge_pair(CAPTURE_DR,       SHIFT_DR,      EXIT1_DR);
    edge_pair(SHIFT_DR,         SHIFT_DR,      EXIT1_DR);
    edge_pair(EXIT1_DR,         PAUSE_DR,      UPDATE_DR);
    edge_pair(PAUSE_DR,         PAUSE_DR,      EXIT2_DR);
    edge_pair(EXIT2_DR,         SHIFT_DR,      UPDATE_DR);
    edge_pair(UPDATE_DR,        RUN_TEST_IDLE, SELECT_DR);
    edge_pair(SELECT_IR,        CAPTURE_IR,    TEST_LOGIC_RESET);
    edge_pair(CAPTURE_IR,       SHIFT_IR,      EXIT1_IR);
    edge_pair(SHIFT_IR,         SHIFT_IR,      EXIT1_IR);
    edge_pair(EXIT1_IR,         PAUSE_IR,      UPDATE_IR);
    edge_pair(PAUSE_IR,         PAUSE_IR,      EXIT2_IR);
    edge_pair(EXIT2_IR,         SHIFT_IR,      UPDATE_IR);
    edge_pair(UPDATE_IR,        RUN_TEST_IDLE, SELECT_DR);
  endtask

  task automatic model_reset();
    m_state = TEST_LOGIC_RESET;
    m_ir    = 5'h01;
    m_irsr  = '0;
    m_dr    = '0;
    m_len   = 1;
    m_user  = '0;
    m_tdo   = 1'b0;
    m_oe    = 1'b0;
  endtask

  task automatic model_rise(input bit tms, input bit tdi);
    tap_state_e s = m_state;
    case (s)
      CAPTURE_IR: m_irsr = 5'b00001;
      SHIFT_IR:   m_irsr = {tdi, m_irsr[4:1]};
      UPDATE_IR:  m_ir = m_irsr;
      CAPTURE_DR: begin
        if (m_ir == 5'h01)      begin m_dr = 64'h1E200A6D; m_len = 32; end
        else if (m_ir == 5'h10) begin m_dr = {32'h0, user_in}; m_len = 32; end
        else                    begin m_dr = '0; m_len = 1; end
      end
      SHIFT_DR:   m_dr = (m_dr >> 1) | (64'(tdi) << (m_len - 1));
      UPDATE_DR: begin
        if (m_ir == 5'h10) begin
          m_user = m_dr[31:0];
          exp_pulses++;
        end
      end
      default: ;
    endcase
    m_state = tms ? nxt1[s] : nxt0[s];
    if (m_state == TEST_LOGIC_RESET) m_ir = 5'h01;
  endtask

  task automatic model_fall();
    m_oe  = (m_state == SHIFT_IR) || (m_state == SHIFT_DR);
    m_tdo = (m_state == SHIFT_IR) ? m_irsr[0] : (m_state == SHIFT_DR) ? m_dr[0] : 1'b0;
  endtask

  task automatic do_check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Single compare process: settled outputs vs model, plus posted literal checks.
  logic last_tck = 1'b0;
  int   settle = 0;
  always @(negedge clk) begin
    if (tck_drv !== last_tck) begin
      last_tck = tck_drv;
      settle = 0;
    end else if (settle < 100) begin
      settle++;
    end
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      do_check(lit_name, lit_got, lit_exp);
    end
    if (check_en && settle == 4) begin
      do_check("state",    64'(tap_state_o),   64'(m_state));
      do_check("ir",       64'(ir_o),          64'(m_ir));
      do_check("tdo",      64'(jtag_tdo_o),    64'(m_tdo));
      do_check("tdo_oe",   64'(jtag_tdo_oe_o), 64'(m_oe));
      do_check("user_dr",  64'(user_dr_o),     64'(m_user));
      do_check("pulses",   64'(dut_pulses),    64'(exp_pulses));
    end
  end

  always @(negedge clk) if (user_update_o === 1'b1) dut_pulses++;

  task automatic post(input string name, input logic [63:0] got, input logic [63:0] exp);
    @(posedge clk); #1;
    lit_name = name;
    lit_got  = got;
    lit_exp  = exp;
    lit_seq++;
    @(posedge clk); #1;
  endtask

  task automatic clock_tck(input bit tms, input bit tdi, output bit tdo_seen);
    @(posedge clk); #1;
    tck_drv = 1'b0;
    model_fall();
    tms_drv = tms;
    tdi_drv = tdi;
    repeat (6) @(posedge clk);
    #1;
    tdo_seen = jtag_tdo_o;
    tck_drv = 1'b1;
    model_rise(tms, tdi);
    repeat (5) @(posedge clk);
  endtask

  task automatic tms_seq(input bit tms, input int n);
    bit b;
    for (int i = 0; i < n; i++) clock_tck(tms, 1'b0, b);
  endtask

  task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    bit b;
    dout = '0;
    clock_tck(1, 0, b); clock_tck(0, 0, b); clock_tck(0, 0, b);
    for (int i = 0; i < n; i++) begin
      clock_tck(i == n - 1, din[i], b);
      dout[i] = b;
    end
    clock_tck(1, 0, b); clock_tck(0, 0, b);
  endtask

  task automatic shift_ir(input logic [4:0] val, output logic [4:0] dout);
    bit b;
    dout = '0;
    clock_tck(1, 0, b); clock_tck(1, 0, b); clock_tck(0, 0, b); clock_tck(0, 0, b);
    for (int i = 0; i < 5; i++) begin
      clock_tck(i == 4, val[i], b);
      dout[i] = b;
    end
    clock_tck(1, 0, b); clock_tck(0, 0, b);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dout;
    logic [4:0]  iout;
    logic [4:0]  rir;
    int          p0, len;
    bit          b;

    build_table();
    model_reset();
    rst_i = 1'b1; tck_drv = 1'b0; tms_drv = 1'b0; tdi_drv = 1'b0; trst_n = 1'b1;
    user_in = 32'h12345678;
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b0;
    post("rst_state",  64'(tap_state_o), 64'hF);
    post("rst_ir",     64'(ir_o), 64'h01);
    post("rst_tdo_oe", {jtag_tdo_o, jtag_tdo_oe_o, user_update_o}, 64'h0);
    post("rst_userdr", 64'(user_dr_o), 64'h0);
    check_en = 1'b1;

    tms_seq(1, 5);
    tms_seq(0, 1);
    shift_dr(32, 64'h0, dout);
    post("idcode_stream", dout[31:0], 64'h1E200A6D);

    shift_ir(5'h10, iout);
    post("ir_capture", 64'(iout), 64'h01);
    post("ir_user", 64'(ir_o), 64'h10);
    p0 = dut_pulses;
    shift_dr(32, 64'hCAFEF00D, dout);
    post("user_tdo", dout[31:0], 64'h12345678);
    post("user_dr_o", 64'(user_dr_o), 64'hCAFEF00D);
    post("model_user", 64'(m_user), 64'hCAFEF00D);
    post("user_pulse", 64'(dut_pulses - p0), 64'h1);

    shift_ir(5'h07, iout);
    p0 = dut_pulses;
    shift_dr(9, 64'hA5, dout);
    post("bypass_stream", dout[8:0], 64'h14A);
    post("bypass_no_pulse", 64'(dut_pulses - p0), 64'h0);

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0: rir = 5'h01;
        1: rir = 5'h10;
        2: rir = 5'h1F;
        default: rir = 5'($urandom);
      endcase
      user_in = $urandom;
      shift_ir(rir, iout);
      len = $urandom_range(1, 40);
      shift_dr(len, {$urandom, $urandom}, dout);
    end
    for (int k = 0; k < 60; k++) clock_tck(1'($urandom), 1'($urandom), b);
    tms_seq(1, 5);
    post("tms_reset_state", 64'(tap_state_o), 64'hF);
    post("tms_reset_ir", 64'(ir_o), 64'h01);
    tms_seq(0, 1);

    shift_ir(5'h10, iout);
    user_in = 32'h0BADBEEF;
    shift_dr(32, 64'hCAFEF00D, dout);
    clock_tck(1, 0, b); clock_tck(0, 0, b); clock_tck(0, 0, b);
    for (int i = 0; i < 5; i++) clock_tck(0, 1'($urandom), b);
    p0 = dut_pulses;
    check_en = 1'b0;
    @(posedge clk); #1 trst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 trst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    m_state = TEST_LOGIC_RESET;
    m_ir = 5'h01;
    post("trst_state", 64'(tap_state_o), 64'hF);
    post("trst_ir", 64'(ir_o), 64'h01);
    post("trst_userdr", 64'(user_dr_o), 64'hCAFEF00D);
    post("trst_no_pulse", 64'(dut_pulses - p0), 64'h0);
    check_en = 1'b1;
    tms_seq(0, 1);

    shift_ir(5'h10, iout);
    clock_tck(1, 0, b); clock_tck(0, 0, b); clock_tck(0, 0, b);
    for (int i = 0; i < 3; i++) clock_tck(0, 1'($urandom), b);
    @(posedge clk); #1;
    tck_drv = 1'b0;
    model_fall();
    repeat (6) @(posedge clk);
    #1;
    p0 = dut_pulses;
    check_en = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    dout = {26'h0, jtag_tdo_o, jtag_tdo_oe_o, user_update_o, tap_state_o, ir_o, user_dr_o};
    model_reset();
    post("midrst_state", 64'(dout[40:37]), 64'hF);
    post("midrst_ir", 64'(dout[36:32]), 64'h01);
    post("midrst_userdr", 64'(dout[31:0]), 64'h0);
    post("midrst_tdo_oe_upd", 64'(dout[43:41]), 64'h0);
    post("midrst_no_pulse", 64'(dut_pulses - p0), 64'h0);
    check_en = 1'b1;

    tms_seq(0, 1);
    shift_dr(32, 64'h0, dout);
    post("idcode_after_rst", dout[31:0], 64'h1E200A6D);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
